multifunction_barrel_shifter: RTL and testbench

MULTIFUNCTION_BARREL_SHIFTER -- requirements
Module: multifunction_barrel_shifter

---
 rtl/multifunction_barrel_shifter_if.sv | 35 +++
 rtl/multifunction_barrel_shifter.sv | 87 ++++++++
 tb/tb_multifunction_barrel_shifter.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/multifunction_barrel_shifter_if.sv
// Operand/result bundle for the multifunction barrel shifter.
// The master side drives the operand, shift distance, mode and qualifier.
// The slave side returns the registered result and its flags.
interface multifunction_barrel_shifter_if #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
);
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_amt;
    logic [1:0]       mode;
    logic             in_valid;
    logic [WIDTH-1:0] data_out;
    logic             out_valid;
    logic             zero;

    modport master (
        output data_in,
        output shift_amt,
        output mode,
        output in_valid,
        input  data_out,
        input  out_valid,
        input  zero
    );

    modport slave (
        input  data_in,
        input  shift_amt,
        input  mode,
        input  in_valid,
        output data_out,
        output out_valid,
        output zero
    );
endinterface

// File: rtl/multifunction_barrel_shifter.sv
// Registered logarithmic barrel shifter.
// Modes: 00 logical left, 01 logical right, 10 arithmetic right, 11 rotate left.
// The result is registered, so latency is one cycle and throughput is one per cycle.
// WIDTH must be a power of two and at least 2.
module multifunction_barrel_shifter #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    multifunction_barrel_shifter_if.slave   bus
);

    logic             sign_w;
    logic [WIDTH-1:0] result_w;

    // The ASR fill always comes from the original operand's MSB. Each
    // intermediate stage keeps that MSB, so every stage can reuse it.
    assign sign_w = bus.data_in[WIDTH-1];

    // Stage gi moves the word by 2**gi when shift_amt[gi] is set. Every
    // stage applies the same mode-dependent fill or wrap.
    genvar gi;
    generate
        for (gi = 0; gi < SHW; gi++) begin : g_stage
            localparam int S = 1 << gi;
            logic [WIDTH-1:0] in_w;
            logic [WIDTH-1:0] moved_w;
            logic [WIDTH-1:0] out_w;

            if (gi == 0) begin : g_first
                assign in_w = bus.data_in;
            end else begin : g_chain
                assign in_w = g_stage[gi-1].out_w;
            end

            // Fixed-distance shift or rotate for this stage, selected by mode.
            always_comb begin
                moved_w = in_w;
                case (bus.mode)
                    2'b00:   moved_w = {in_w[WIDTH-1-S:0], {S{1'b0}}};
                    2'b01:   moved_w = {{S{1'b0}}, in_w[WIDTH-1:S]};
                    2'b10:   moved_w = {{S{sign_w}}, in_w[WIDTH-1:S]};
                    default: moved_w = {in_w[WIDTH-1-S:0], in_w[WIDTH-1:WIDTH-S]};
                endcase
            end

            assign out_w = bus.shift_amt[gi] ? moved_w : in_w;
        end
    endgenerate

    assign result_w = g_stage[SHW-1].out_w;

    logic [WIDTH-1:0] data_q,  data_d;
    logic             zero_q,  zero_d;
    logic             valid_q, valid_d;

    // Next state: load a new result on an accepted operation, otherwise hold.
    always_comb begin
        data_d  = data_q;
        zero_d  = zero_q;
        valid_d = bus.in_valid;
        if (bus.in_valid) begin
            data_d = result_w;
            zero_d = (result_w == '0);
        end
    end

    // Output registers. An asynchronous reset clears them at once and drops
    // any operation that is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q  <= '0;
            zero_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            data_q  <= data_d;
            zero_q  <= zero_d;
            valid_q <= valid_d;
        end
    end

    assign bus.data_out  = data_q;
    assign bus.zero      = zero_q;
    assign bus.out_valid = valid_q;

endmodule

// File: tb/tb_multifunction_barrel_shifter.sv
// Self-checking bench for multifunction_barrel_shifter (WIDTH=8).
// The bench uses directed vectors and random traffic. Results are compared
// with an arithmetic reference model.
module tb_multifunction_barrel_shifter;

    localparam int WIDTH = 8;
    localparam int SHW   = 3;

    logic clk;
    logic rst;

    multifunction_barrel_shifter_if #(.WIDTH(WIDTH), .SHW(SHW)) bus ();

    multifunction_barrel_shifter #(.WIDTH(WIDTH), .SHW(SHW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Expected registered state tracked by the bench.
    logic [7:0] exp_data;
    logic       exp_zero;
    logic       exp_valid;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model built from the mode rules with plain integer arithmetic.
    function automatic logic [7:0] ref_model(input logic [7:0] d, input int n, input logic [1:0] m);
        int v;
        int r;
        v = int'(d);
        case (m)
            2'b00: r = (v * (1 << n)) % 256;
            2'b01: r = v / (1 << n);
            2'b10: begin
                if (v >= 128) r = v - 256; else r = v;
                // Floor division of a negative value gives an arithmetic shift.
                if (r < 0) r = -((-r + (1 << n) - 1) / (1 << n));
                else       r = r / (1 << n);
                r = (r + 256) % 256;
            end
            default: r = ((v * (1 << n)) % 256) + (v / (1 << (8 - n)) % 256) * ((n == 0) ? 0 : 1);
        endcase
        return r[7:0];
    endfunction

    task automatic check_outputs(input string tag);
        check_val({tag, "_data"},  32'(bus.data_out),  32'(exp_data));
        check_val({tag, "_zero"},  32'(bus.zero),      32'(exp_zero));
        check_val({tag, "_valid"}, 32'(bus.out_valid), 32'(exp_valid));
    endtask

    // Drive one cycle of inputs, let the edge happen, and update the model.
    task automatic do_op(input logic [7:0] d, input logic [2:0] a, input logic [1:0] m, input logic v);
        logic [7:0] r;
        @(negedge clk);
        bus.data_in   = d;
        bus.shift_amt = a;
        bus.mode      = m;
        bus.in_valid  = v;
        @(posedge clk);
        #1;
        if (v) begin
            r        = ref_model(d, int'(a), m);
            exp_data = r;
            exp_zero = (r == 8'h00);
        end
        exp_valid = v;
    endtask

    logic [7:0] vec_d   [4];
    logic [7:0] vec_024 [4];
    logic [7:0] vec_026 [4];

    initial begin
        n_cmp = 0;
        n_err = 0;
        vec_024[0] = 8'b01010000; vec_024[1] = 8'b00010101;
        vec_024[2] = 8'b11110101; vec_024[3] = 8'b01010101;
        vec_026[0] = 8'b10000000; vec_026[1] = 8'b00000001;
        vec_026[2] = 8'b11111111; vec_026[3] = 8'b11000000;

        rst           = 1'b1;
        bus.data_in   = 8'hA5;
        bus.shift_amt = 3'd1;
        bus.mode      = 2'b00;
        bus.in_valid  = 1'b1;
        exp_data  = 8'h00;
        exp_zero  = 1'b0;
        exp_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        bus.in_valid = 1'b0;
        rst = 1'b0;

        // Each mode on 10101010 shifted by 3.
        for (int i = 0; i < 4; i++) begin
            do_op(8'b10101010, 3'd3, 2'(i), 1'b1);
            $display("op d=aa amt=3 mode=%0d -> %b", i, bus.data_out);
            check_val("req024_const", 32'(bus.data_out), 32'(vec_024[i]));
            check_outputs("req024");
        end

        // A shift distance of zero passes the operand through in every mode.
        for (int i = 0; i < 4; i++) begin
            do_op(8'b01101001, 3'd0, 2'(i), 1'b1);
            $display("op d=69 amt=0 mode=%0d -> %b", i, bus.data_out);
            check_val("req025_const", 32'(bus.data_out), 32'h69);
            check_outputs("req025");
        end

        // Maximum shift distance.
        for (int i = 0; i < 4; i++) begin
            do_op(8'b10000001, 3'd7, 2'(i), 1'b1);
            $display("op d=81 amt=7 mode=%0d -> %b", i, bus.data_out);
            check_val("req026_const", 32'(bus.data_out), 32'(vec_026[i]));
            check_outputs("req026");
        end

        // Zero flag set, then cleared.
        do_op(8'b00001111, 3'd4, 2'b01, 1'b1);
        $display("op d=0f amt=4 mode=1 -> %b zero=%b", bus.data_out, bus.zero);
        check_val("req027_z1_data", 32'(bus.data_out), 32'h00);
        check_val("req027_z1_flag", 32'(bus.zero), 32'h1);
        do_op(8'b00001111, 3'd4, 2'b00, 1'b1);
        $display("op d=0f amt=4 mode=0 -> %b zero=%b", bus.data_out, bus.zero);
        check_val("req027_z0_data", 32'(bus.data_out), 32'hF0);
        check_val("req027_z0_flag", 32'(bus.zero), 32'h0);

        // Hold: random inputs with in_valid low.
        for (int i = 0; i < 5; i++) begin
            do_op(8'($urandom), 3'($urandom), 2'($urandom), 1'b0);
            $display("hold cycle %0d -> %b valid=%b", i, bus.data_out, bus.out_valid);
            check_val("req028_data", 32'(bus.data_out), 32'hF0);
            check_outputs("req028");
        end

        // Random traffic, including back-to-back accepted operations.
        for (int i = 0; i < 300; i++) begin
            do_op(8'($urandom), 3'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
            $display("rnd %0d d=%h amt=%0d mode=%0d v=%b -> %h z=%b ov=%b", i, bus.data_in,
                     bus.shift_amt, bus.mode, bus.in_valid, bus.data_out, bus.zero, bus.out_valid);
            check_outputs("rand");
        end

        // Asynchronous reset between edges while out_valid is high.
        do_op(8'hFF, 3'd1, 2'b00, 1'b1);
        check_val("req029_pre_valid", 32'(bus.out_valid), 32'h1);
        #2;
        rst = 1'b1;
        #1;
        exp_data  = 8'h00;
        exp_zero  = 1'b0;
        exp_valid = 1'b0;
        $display("async rst -> %h valid=%b zero=%b", bus.data_out, bus.out_valid, bus.zero);
        check_outputs("req029_async");
        // The operation in flight must not produce a pulse.
        @(posedge clk);
        #1;
        check_outputs("req029_inrst");
        @(negedge clk);
        rst = 1'b0;
        do_op(8'b00000011, 3'd2, 2'b11, 1'b1);
        $display("post rst op -> %b valid=%b", bus.data_out, bus.out_valid);
        check_val("req029_post_const", 32'(bus.data_out), 32'h0C);
        check_outputs("req029_post");
        do_op(8'h00, 3'd0, 2'b00, 1'b0);
        check_outputs("req029_drop");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
